rl_pair_scheduler: RTL and testbench

Parametrised pair-address scheduler for the range-limited force pipeline. It walks home and neighbour particle indices, drives the read addresses and read enable of the position BRAMs, and emits a `pair_valid` strobe aligned with BRAM read data, for the downstream `r2_compute`.

It generalises the fixed 512×512 walk to:
- configurable home/neighbour counts and BRAM read latency;
- a half-shell mode (j > i only, Newton's third law);
- downstream stall;
- a pair counter and a `busy`/`done` handshake.

---
 rtl/rl_pair_scheduler_pkg.sv | 26 ++
 rtl/rl_pair_scheduler_if.sv | 29 ++
 rtl/rl_pair_scheduler_valid_delay.sv | 40 ++++
 rtl/rl_pair_scheduler.sv | 138 +++++++++++++
 tb/tb_rl_pair_scheduler.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/rl_pair_scheduler_pkg.sv
// Shared types and constants for the range-limited pair scheduler.
package rl_pkg;

  // Scheduler control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rl_state_e;

  // Deepest BRAM read pipeline the valid delay line supports.
  localparam int unsigned RL_MAX_RD_LATENCY = 4;

  // Clamp a requested read latency into the supported 1..RL_MAX_RD_LATENCY range.
  function automatic int unsigned rl_clamp_latency(input int unsigned lat);
    if (lat < 1) begin
      return 1;
    end
    if (lat > RL_MAX_RD_LATENCY) begin
      return RL_MAX_RD_LATENCY;
    end
    return lat;
  endfunction

endpackage

// File: rtl/rl_pair_scheduler_if.sv
// Control and BRAM-address bundle between the scheduler and its environment.
interface rl_pair_scheduler_if #(
  parameter int unsigned HOME_ADDR_WIDTH = 9,
  parameter int unsigned NBR_ADDR_WIDTH  = 9,
  parameter int unsigned COUNT_WIDTH     = 20
);
  logic                       start;
  logic                       half_mode;
  logic                       stall;
  logic [HOME_ADDR_WIDTH-1:0] home_rdaddr;
  logic [NBR_ADDR_WIDTH-1:0]  nbr_rdaddr;
  logic                       rden;
  logic                       pair_valid;
  logic                       busy;
  logic                       done;
  logic [COUNT_WIDTH-1:0]     pair_count;

  // Scheduler side: accepts run control, drives the BRAM read port and status.
  modport master (
    input  start, half_mode, stall,
    output home_rdaddr, nbr_rdaddr, rden, pair_valid, busy, done, pair_count
  );

  // Controller side: issues run control, observes addresses and status.
  modport slave (
    output start, half_mode, stall,
    input  home_rdaddr, nbr_rdaddr, rden, pair_valid, busy, done, pair_count
  );
endinterface

// File: rtl/rl_pair_scheduler_valid_delay.sv
// Read-enable to data-valid delay line matching the BRAM read latency.
module rl_valid_delay
  import rl_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  output logic valid_o,
  output logic inflight_o
);

  logic [RD_LATENCY-1:0] sr_q;
  logic [RD_LATENCY-1:0] sr_d;

  // Shift the incoming strobe one stage per cycle; the line never freezes.
  always_comb begin
    sr_d    = '0;
    sr_d[0] = valid_i;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Delay-line register, cleared asynchronously so in-flight beats are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign valid_o    = sr_q[RD_LATENCY-1];
  // Looks one cycle ahead: true while a beat will still be in the line after
  // this cycle, so DRAIN can leave exactly one cycle after the last beat.
  assign inflight_o = |sr_d;

endmodule

// File: rtl/rl_pair_scheduler.sv
// Home/neighbour pair-address walker feeding the position BRAMs of the
// range-limited force pipeline, with half-shell mode and downstream stall.
module rl_pair_scheduler
  import rl_pkg::*;
#(
  parameter int unsigned HOME_NUM        = 512,
  parameter int unsigned NBR_NUM         = 512,
  parameter int unsigned HOME_ADDR_WIDTH = 9,
  parameter int unsigned NBR_ADDR_WIDTH  = 9,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned COUNT_WIDTH     = 20
) (
  input  logic               clk,
  input  logic               rst,
  rl_pair_scheduler_if.master bus
);

  localparam int unsigned LAT = rl_clamp_latency(RD_LATENCY);

  localparam logic [HOME_ADDR_WIDTH-1:0] HOME_LAST      = HOME_ADDR_WIDTH'(HOME_NUM - 1);
  localparam logic [HOME_ADDR_WIDTH-1:0] HALF_HOME_LAST =
      HOME_ADDR_WIDTH'((HOME_NUM > 1) ? (HOME_NUM - 2) : 0);
  localparam logic [NBR_ADDR_WIDTH-1:0]  NBR_LAST       = NBR_ADDR_WIDTH'(NBR_NUM - 1);

  rl_state_e                  state_q, state_d;
  logic [HOME_ADDR_WIDTH-1:0] home_q, home_d;
  logic [NBR_ADDR_WIDTH-1:0]  nbr_q, nbr_d;
  logic                       mode_q, mode_d;
  logic [COUNT_WIDTH-1:0]     count_q, count_d;
  logic                       rden;
  logic                       last_pair;
  logic                       pair_valid;
  logic                       inflight;

  // Next-state, address walk and read-enable decode.
  always_comb begin
    state_d   = state_q;
    home_d    = home_q;
    nbr_d     = nbr_q;
    mode_d    = mode_q;
    rden      = 1'b0;
    last_pair = (home_q == (mode_q ? HALF_HOME_LAST : HOME_LAST)) && (nbr_q == NBR_LAST);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d = bus.half_mode;
          home_d = '0;
          if (bus.half_mode && (HOME_NUM == 1)) begin
            // Half shell over a single particle has no j > i pair.
            nbr_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            nbr_d   = bus.half_mode ? NBR_ADDR_WIDTH'(1) : '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          rden = 1'b1;
          if (last_pair) begin
            state_d = ST_DRAIN;
          end else if (nbr_q == NBR_LAST) begin
            home_d = home_q + HOME_ADDR_WIDTH'(1);
            // Half shell restarts the row just above the next home index.
            nbr_d  = mode_q ? (NBR_ADDR_WIDTH'(home_q) + NBR_ADDR_WIDTH'(2)) : '0;
          end else begin
            nbr_d = nbr_q + NBR_ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!inflight) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pair counter: cleared by an accepted start, stepped by each valid beat.
  always_comb begin
    count_d = count_q;
    if ((state_q == ST_IDLE) && bus.start) begin
      count_d = '0;
    end else if (pair_valid) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address, mode and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      home_q  <= '0;
      nbr_q   <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
    end else begin
      home_q  <= home_d;
      nbr_q   <= nbr_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

  rl_valid_delay #(
    .RD_LATENCY (LAT)
  ) u_valid_delay (
    .clk        (clk),
    .rst_n      (rst),
    .valid_i    (rden),
    .valid_o    (pair_valid),
    .inflight_o (inflight)
  );

  assign bus.home_rdaddr = home_q;
  assign bus.nbr_rdaddr  = nbr_q;
  assign bus.rden        = rden;
  assign bus.pair_valid  = pair_valid;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.pair_count  = count_q;

endmodule

// File: tb/tb_rl_pair_scheduler.sv
// Directed bench for rl_pair_scheduler: three instances (4x4 latency 1,
// 4x4 latency 2, 1x1 latency 1) share the control inputs; one is observed per run.
module tb_rl_pair_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic half_mode;
  logic stall;

  always #5 clk = ~clk;

  rl_pair_scheduler_if #(.HOME_ADDR_WIDTH(2), .NBR_ADDR_WIDTH(2), .COUNT_WIDTH(8)) ifa ();
  rl_pair_scheduler_if #(.HOME_ADDR_WIDTH(2), .NBR_ADDR_WIDTH(2), .COUNT_WIDTH(8)) ifb ();
  rl_pair_scheduler_if #(.HOME_ADDR_WIDTH(1), .NBR_ADDR_WIDTH(1), .COUNT_WIDTH(8)) ifc ();

  assign ifa.start = start;  assign ifa.half_mode = half_mode;  assign ifa.stall = stall;
  assign ifb.start = start;  assign ifb.half_mode = half_mode;  assign ifb.stall = stall;
  assign ifc.start = start;  assign ifc.half_mode = half_mode;  assign ifc.stall = stall;

  rl_pair_scheduler #(
    .HOME_NUM(4), .NBR_NUM(4), .HOME_ADDR_WIDTH(2), .NBR_ADDR_WIDTH(2),
    .RD_LATENCY(1), .COUNT_WIDTH(8)
  ) u_a (.clk(clk), .rst(rst), .bus(ifa));

  rl_pair_scheduler #(
    .HOME_NUM(4), .NBR_NUM(4), .HOME_ADDR_WIDTH(2), .NBR_ADDR_WIDTH(2),
    .RD_LATENCY(2), .COUNT_WIDTH(8)
  ) u_b (.clk(clk), .rst(rst), .bus(ifb));

  rl_pair_scheduler #(
    .HOME_NUM(1), .NBR_NUM(1), .HOME_ADDR_WIDTH(1), .NBR_ADDR_WIDTH(1),
    .RD_LATENCY(1), .COUNT_WIDTH(8)
  ) u_c (.clk(clk), .rst(rst), .bus(ifc));

  int          sel;
  logic [1:0]  o_home, o_nbr;
  logic        o_rden, o_pv, o_busy, o_done;
  logic [7:0]  o_cnt;

  always_comb begin
    o_home = ifa.home_rdaddr; o_nbr = ifa.nbr_rdaddr; o_rden = ifa.rden;
    o_pv   = ifa.pair_valid;  o_busy = ifa.busy;      o_done = ifa.done;
    o_cnt  = ifa.pair_count;
    if (sel == 1) begin
      o_home = ifb.home_rdaddr; o_nbr = ifb.nbr_rdaddr; o_rden = ifb.rden;
      o_pv   = ifb.pair_valid;  o_busy = ifb.busy;      o_done = ifb.done;
      o_cnt  = ifb.pair_count;
    end else if (sel == 2) begin
      o_home = {1'b0, ifc.home_rdaddr}; o_nbr = {1'b0, ifc.nbr_rdaddr}; o_rden = ifc.rden;
      o_pv   = ifc.pair_valid;          o_busy = ifc.busy;              o_done = ifc.done;
      o_cnt  = ifc.pair_count;
    end
  end

  typedef struct {
    int sel;
    int half;
    int stall_lo;
    int stall_hi;
    int poke;
    int exp_pairs;
    int exp_done;
    int exp_sbeats;
  } vec_t;

  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;
  int   exp_h[$];
  int   exp_n[$];
  int   rden_hist[64];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic build_model(input int hn, input int nn, input int half);
    exp_h.delete();
    exp_n.delete();
    for (int i = 0; i < hn; i++) begin
      for (int j = 0; j < nn; j++) begin
        if (half == 0 || j > i) begin
          exp_h.push_back(i);
          exp_n.push_back(j);
        end
      end
    end
  endtask

  task automatic wait_idle();
    int ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!ifa.busy && !ifb.busy && !ifc.busy) begin
        ok = 1;
        break;
      end
    end
    check("idle_timeout", ok, 1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int hn, lat, issued, beats, sbeats, done_cyc;
    int busy_bad, range_bad, frz_bad, align_bad, exp_pv;
    logic [1:0] prev_home, prev_nbr;
    v   = vecs[idx];
    hn  = (v.sel == 2) ? 1 : 4;
    lat = (v.sel == 1) ? 2 : 1;
    build_model(hn, hn, v.half);
    wait_idle();
    sel = v.sel;
    issued = 0; beats = 0; sbeats = 0; done_cyc = -1;
    busy_bad = 0; range_bad = 0; frz_bad = 0; align_bad = 0;
    prev_home = '0; prev_nbr = '0;
    for (int k = 0; k < 64; k++) rden_hist[k] = 0;
    half_mode = v.half[0];
    stall     = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      stall = (cyc >= v.stall_lo && cyc <= v.stall_hi && v.stall_lo > 0);
      if (cyc == v.poke) begin
        start = 1'b1; half_mode = ~v.half[0];
      end else begin
        start = 1'b0; half_mode = v.half[0];
      end
      #1;
      if (cyc == 1) check("count_cleared", int'(o_cnt), 0);
      if (!o_busy) busy_bad++;
      if (int'(o_home) > hn - 1 || int'(o_nbr) > hn - 1) range_bad++;
      if (stall && (o_rden || (cyc > v.stall_lo && (o_home != prev_home || o_nbr != prev_nbr))))
        frz_bad++;
      rden_hist[cyc] = int'(o_rden);
      exp_pv = (cyc - lat >= 1) ? rden_hist[cyc - lat] : 0;
      if (int'(o_pv) != exp_pv) align_bad++;
      if (o_rden) begin
        if (issued < exp_h.size())
          check("pair_order", int'(o_home) * 16 + int'(o_nbr), exp_h[issued] * 16 + exp_n[issued]);
        issued++;
      end
      if (o_pv) begin
        beats++;
        if (v.stall_lo > 0 && cyc >= v.stall_lo && cyc <= v.stall_hi + lat) sbeats++;
      end
      prev_home = o_home;
      prev_nbr  = o_nbr;
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0; stall = 1'b0;
    check("done_cycle", done_cyc, v.exp_done);
    check("issued_pairs", issued, v.exp_pairs);
    check("valid_beats", beats, v.exp_pairs);
    check("pair_count", int'(o_cnt), v.exp_pairs);
    check("busy_gaps", busy_bad, 0);
    check("addr_range", range_bad, 0);
    check("valid_alignment", align_bad, 0);
    if (v.stall_lo > 0) begin
      check("stall_freeze", frz_bad, 0);
      check("beats_after_stall", sbeats, v.exp_sbeats);
    end
    @(negedge clk);
    #1;
    check("idle_after_done", int'({o_busy, o_done}), 0);
    check("count_hold", int'(o_cnt), v.exp_pairs);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_a"}, int'({ifa.home_rdaddr, ifa.nbr_rdaddr, ifa.rden, ifa.pair_valid,
                              ifa.busy, ifa.done, ifa.pair_count}), 0);
    check({name, "_b"}, int'({ifb.home_rdaddr, ifb.nbr_rdaddr, ifb.rden, ifb.pair_valid,
                              ifb.busy, ifb.done, ifb.pair_count}), 0);
    check({name, "_c"}, int'({ifc.home_rdaddr, ifc.nbr_rdaddr, ifc.rden, ifc.pair_valid,
                              ifc.busy, ifc.done, ifc.pair_count}), 0);
  endtask

  initial begin
    //            sel half lo hi poke pairs done sbeats
    vecs[0] = '{0, 0, 0, 0, 0, 16, 18, 0};  // full 4x4, latency 1
    vecs[1] = '{0, 1, 0, 0, 0,  6,  8, 0};  // half 4x4, latency 1
    vecs[2] = '{1, 0, 3, 5, 0, 16, 22, 2};  // full 4x4, latency 2, stall 3..5
    vecs[3] = '{2, 1, 0, 0, 0,  0,  2, 0};  // half 1x1: zero-pair run
    vecs[4] = '{0, 0, 0, 0, 5, 16, 18, 0};  // start pulsed mid-run is ignored
    vecs[5] = '{1, 1, 0, 0, 0,  6,  9, 0};  // half 4x4, latency 2
    vecs[6] = '{2, 0, 0, 0, 0,  1,  3, 0};  // full 1x1, single pair

    sel = 0; rst = 1'b0; start = 1'b0; half_mode = 1'b0; stall = 1'b0;
    #3;
    check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(i);
    end

    // Reset in the middle of a full run, then restart cleanly.
    wait_idle();
    sel = 0;
    half_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("busy_before_reset", int'(o_busy), 1);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b1;
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
